// File: rtl/mult11_share_arbiter.sv
// Round-robin arbiter sharing one 11x11 unsigned multiplier between NUM_REQ
// requesters; one transaction in flight, product returned with requester id.

module multiplier_11bit (
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [22:0] answer
);
    assign answer = {12'd0, a} * {12'd0, b};
endmodule

module mult11_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*11-1:0] req_a,
    input  logic [NUM_REQ*11-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [21:0]           rsp_product,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);
    // state  | meaning
    // S_IDLE | no transaction, accept window open
    // S_MUL  | multiplier evaluating registered operands
    // S_DONE | product valid, waiting for rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    op_id;
    logic [10:0]        op_a, op_b;
    logic [10:0]        sel_a, sel_b;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      scan_idx;
    logic               grant_found;
    logic               accept_win;
    logic               transfer;
    logic [22:0]        answer;
    logic               answer_msb_unused;

    multiplier_11bit u_mul (
        .a      (op_a),
        .b      (op_b),
        .answer (answer)
    );
    assign answer_msb_unused = answer[22];

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_oh    = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found                   = 1'b1;
                grant_id                      = scan_idx[ID_W-1:0];
                grant_oh[scan_idx[ID_W-1:0]]  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a = req_a[11*i +: 11];
                sel_b = req_b[11*i +: 11];
            end
        end
    end

    assign req_ready = (accept_win && rst_n) ? grant_oh : '0;
    assign transfer  = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (transfer) state_nxt = S_MUL;
            S_MUL:  state_nxt = S_DONE;
            S_DONE: if (rsp_ready) state_nxt = transfer ? S_MUL : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept_win = (state == S_IDLE) || ((state == S_DONE) && rsp_ready);
        rsp_valid  = (state == S_DONE);
        busy       = (state == S_MUL) || (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
            done_cnt    <= '0;
        end else begin
            if (transfer) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_id  <= grant_id;
                rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            end
            if (state == S_MUL) begin
                rsp_product <= answer[21:0];
                rsp_id      <= op_id;
            end
            if (rsp_valid && rsp_ready)
                done_cnt <= done_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mult11_share_arbiter.sv
// Directed and randomized checks of mult11_share_arbiter against a simple
// round-robin / product model kept in the bench.

module tb_mult11_share_arbiter;
    localparam int NR    = 4;
    localparam int CNT_W = 8;

    logic              clk = 0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*11-1:0]  req_a, req_b;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid, rsp_ready, busy;
    logic [1:0]        rsp_id;
    logic [21:0]       rsp_product;
    logic [CNT_W-1:0]  done_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;
    int m_a [NR];
    int m_b [NR];

    mult11_share_arbiter #(.NUM_REQ(NR), .ID_W(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        m_a[i] = a;
        m_b[i] = b;
        req_a[11*i +: 11] = 11'(a);
        req_b[11*i +: 11] = 11'(b);
    endtask

    function automatic int exp_grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++)
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        return (g < 0) ? '0 : NR'(1) << g;
    endfunction

    // One isolated transaction starting from IDLE; stall cycles in DONE first.
    task automatic txn(input logic [NR-1:0] v, input int stall);
        int g;
        int prod;
        g = exp_grant(v, m_ptr);
        req_valid = v;
        #1;
        chk("txn_grant", req_ready, onehot(g));
        if (g < 0) begin
            req_valid = '0;
            tick();
            chk("txn_idle_busy", busy, 0);
            return;
        end
        prod = m_a[g] * m_b[g];
        m_ptr = (g + 1) % NR;
        tick();
        req_valid = '0;
        chk("txn_mul_busy", {rsp_valid, busy}, 2'b01);
        tick();
        for (int s = 0; s < stall; s++) begin
            req_valid = v;
            #1;
            chk("txn_stall_ready", req_ready, 0);
            chk("txn_stall_prod", rsp_product, prod);
            tick();
            req_valid = '0;
        end
        chk("txn_valid", rsp_valid, 1);
        chk("txn_id", rsp_id, g);
        chk("txn_prod", rsp_product, prod);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        chk("txn_cnt", done_cnt, m_cnt);
        chk("txn_after_valid", rsp_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", done_cnt, 0);
        tick();
        @(negedge clk);
        rst_n = 1;
        m_ptr = 0;
        m_cnt = 0;
        #1;
    endtask

    initial begin
        rst_n = 1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 0;
        for (int i = 0; i < NR; i++) set_ops(i, 0, 0);
        #2;
        req_valid = 4'b1111;
        do_reset();
        req_valid = '0;
        chk("rst_product", rsp_product, 0);
        chk("rst_id", rsp_id, 0);

        // Test 1: single request
        tick();
        set_ops(0, 3, 5);
        txn(4'b0001, 0);

        // Test 2: all held valid, rsp_ready high, back-to-back grants
        do_reset();
        tick();
        for (int i = 0; i < NR; i++) set_ops(i, i + 1, 100);
        req_valid = 4'b1111;
        rsp_ready = 1;
        #1;
        for (int n = 0; n < 5; n++) begin
            chk("rr_grant", req_ready, onehot(n % NR));
            tick();
            chk("rr_mul_ready", req_ready, 0);
            tick();
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, n % NR);
            chk("rr_prod", rsp_product, ((n % NR) + 1) * 100);
            m_cnt++;
        end
        req_valid = '0;
        tick();
        rsp_ready = 0;
        m_ptr = 1;
        chk("rr_cnt", done_cnt, m_cnt);
        chk("rr_idle", busy, 0);

        // Test 3: max operands with back-pressure
        set_ops(1, 2047, 2047);
        txn(4'b0010, 5);
        tick();
        chk("bp_single_hs", done_cnt, m_cnt);

        // Test 4: wrap-around from rr_ptr=3 to requester 2
        set_ops(2, 7, 9);
        txn(4'b0100, 0);
        set_ops(2, 0, 1234);
        txn(4'b0100, 1);

        // Test 5: reset while in MUL
        set_ops(3, 100, 200);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        chk("mr_busy", busy, 1);
        #2;
        rst_n = 0;
        #1;
        chk("mr_valid", rsp_valid, 0);
        chk("mr_busy_rst", busy, 0);
        chk("mr_cnt", done_cnt, 0);
        tick();
        @(negedge clk);
        rst_n = 1;
        m_ptr = 0;
        m_cnt = 0;
        rsp_ready = 1;
        tick();
        tick();
        chk("mr_no_stale", rsp_valid, 0);
        chk("mr_cnt_after", done_cnt, 0);
        rsp_ready = 0;

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) set_ops(i, $urandom_range(2047), $urandom_range(2047));
            txn(NR'($urandom_range(15)), $urandom_range(3));
        end

        // Counter wrap
        while (m_cnt != (1 << CNT_W) - 1) begin
            for (int i = 0; i < NR; i++) set_ops(i, $urandom_range(2047), $urandom_range(2047));
            txn(NR'($urandom_range(1, 15)), 0);
        end
        chk("cnt_max", done_cnt, (1 << CNT_W) - 1);
        txn(4'b0001, 0);
        chk("cnt_wrap", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
